mlab_rd_prefetch: RTL
=====================

MLAB_RD_PREFETCH -- requirements
Module: mlab_rd_prefetch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, giving the RAM address width; RAM depth is 2**ADDR_WIDTH.
REQ-003 SHALL have ports: rclk  input  1  read-side clock, the single clock of the block.
REQ-004 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: wptr  input  ADDR_WIDTH+1  write pointer, binary, already synchronized into rclk.
REQ-006 SHALL have ports: flush  input  1  synchronous discard of all unread data.
REQ-007 SHALL have ports: re  output  1  RAM read enable.
REQ-008 SHALL have ports: raddr  output  ADDR_WIDTH  RAM read address.
REQ-009 SHALL have ports: mem_dout  input  WIDTH  RAM registered read data, valid one rclk after re.
REQ-010 SHALL have ports: rptr  output  ADDR_WIDTH+1  read pointer returned to the write side.
REQ-011 SHALL have ports: m_valid  output  1  output word valid.
REQ-012 SHALL have ports: m_ready  input  1  consumer accepts the word.
REQ-013 SHALL have ports: m_data  output  WIDTH  output word.

Function
REQ-014 SHALL keep an internal binary read pointer rp (ADDR_WIDTH+1 bits); empty = (rp == wptr); rp wraps modulo 2**(ADDR_WIDTH+1).
REQ-015 SHALL hold a 2-entry output buffer (occ 0..2) plus an in-flight flag inf (0..1); pop = m_valid & m_ready.
REQ-016 SHALL assert re combinationally when !empty & !flush & !rst & (occ + inf - pop) < 2.
REQ-017 SHALL drive raddr = rp[ADDR_WIDTH-1:0] at all times; on each rclk edge with re=1, rp increments by 1 and inf is set; otherwise inf clears.
REQ-018 SHALL write mem_dout into the buffer tail on the edge following an re cycle (inf=1); buffer is strict FIFO order.
REQ-019 SHALL drive m_valid = (occ != 0) and m_data = head entry; m_data is held stable while m_valid & !m_ready.
REQ-020 SHALL give latency: wptr becoming != rp in cycle N with empty buffer -> re in N -> m_valid in N+2.
REQ-021 SHALL sustain one word per cycle with m_ready held high and RAM non-empty.
REQ-022 SHALL handle a simultaneous capture and pop in one edge by leaving occ unchanged and advancing the head.
REQ-023 SHALL never overflow the buffer; with m_ready low, re stops once occ + inf = 2.
REQ-024 SHALL, on flush=1, load rp <= wptr, clear occ and inf, discard any returning mem_dout, and hold re=0 that cycle; m_valid is 0 from the next cycle.
REQ-025 SHALL ignore m_ready while m_valid=0.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear rp, occ, inf, buffer contents and m_data to 0; m_valid=0, re=0, rptr=0.
REQ-027 SHALL resume normal operation on the first rclk edge after rst deasserts; an in-flight read at reset is discarded.

Configuration
REQ-028 SHALL, when macro MLAB_RD_GRAY_EN is defined, drive rptr as the Gray code of rp from a register (bin ^ bin>>1), updated on the same edge as rp.
REQ-029 SHALL, when MLAB_RD_GRAY_EN is undefined, drive rptr = rp in binary; all other behaviour is identical.

Verification
REQ-030 SHALL test single word: reset, wptr 0->1 in cycle N, m_ready=1, RAM[0]=0xA5 -> re in N, raddr=0, m_valid in N+2, m_data=0xA5, rptr=1.
REQ-031 SHALL test streaming: wptr=16, m_ready=1 -> 16 consecutive m_valid cycles, data RAM[0..15] in order, no bubbles.
REQ-032 SHALL test backpressure: wptr=8, m_ready=0 -> exactly 2 re pulses, m_data held at RAM[0]; on m_ready=1, words 0..7 in order with no loss or duplication.
REQ-033 SHALL test wrap: ADDR_WIDTH=5, rp=62, wptr=2 (wrapped) -> raddr sequence 30,31,0,1, rptr binary 63,0,1,2; with MLAB_RD_GRAY_EN, rptr = 0x20,0x00,0x01,0x03.
REQ-034 SHALL test flush: flush pulsed with occ=2 and inf=1, wptr=20 -> next cycle m_valid=0, rptr=20, re=0 in the flush cycle.
REQ-035 SHALL test reset mid-stream: rst asserted during streaming -> m_valid, re and rptr go to 0 without an rclk edge.

Source files
------------

// File: rtl/mlab_rd_prefetch.sv
// mlab_rd_prefetch
//   Read-side prefetcher for an MLAB-style RAM with a registered read port.
//   Keeps a 2-entry output buffer topped up from the RAM so that a
//   valid/ready consumer sees one word per cycle with the RAM's read
//   latency hidden.
//
// Parameters
//   WIDTH       data word width
//   ADDR_WIDTH  RAM address width (depth = 2**ADDR_WIDTH)
//
// Ports
//   rclk      in   single clock of the block
//   rst       in   asynchronous active-high reset
//   wptr      in   binary write pointer (ADDR_WIDTH+1), already in rclk domain
//   flush     in   drop everything unread, read pointer jumps to wptr
//   re        out  RAM read enable
//   raddr     out  RAM read address
//   mem_dout  in   RAM read data, valid one rclk after re
//   rptr      out  read pointer back to the write side
//   m_valid   out  output word valid
//   m_ready   in   consumer accepts word
//   m_data    out  output word
//
// Configuration
//   MLAB_RD_GRAY_EN  defined: rptr is a registered Gray code of the read
//                    pointer; undefined: rptr is the binary read pointer.

module mlab_rd_prefetch #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr,
  input  logic                  flush,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data
);

  logic [ADDR_WIDTH:0]       rp, rp_nxt;
  logic [1:0]                occ;    // words held in the buffer
  logic                      inf;    // a RAM read returns this cycle
  logic                      hd;     // buffer head slot
  logic                      tail;   // slot the returning word lands in
  logic [1:0][WIDTH-1:0]     ent_q;
  logic                      empty, pop;
  logic [2:0]                lvl;

  assign empty   = (rp == wptr);
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = ent_q[hd];
  assign raddr   = rp[ADDR_WIDTH-1:0];

  // Occupancy the buffer will have after this edge if no new read is issued;
  // a new read is allowed only if its word will still find a free slot.
  assign lvl = {1'b0, occ} + {2'b00, inf} - {2'b00, pop};
  assign re  = !empty && !flush && !rst && (lvl < 3'd2);

  // Two slots: tail is head when empty or full, the other slot when occ=1.
  assign tail = hd ^ occ[0];

  assign rp_nxt = flush ? wptr : rp + {{ADDR_WIDTH{1'b0}}, re};

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      occ   <= 2'd0;
      inf   <= 1'b0;
      hd    <= 1'b0;
      ent_q <= '0;
    end else begin
      rp <= rp_nxt;
      if (flush) begin
        // Returning word (if any) is simply not captured.
        occ <= 2'd0;
        inf <= 1'b0;
        hd  <= 1'b0;
      end else begin
        inf <= re;
        if (inf) ent_q[tail] <= mem_dout;
        if (pop) hd <= ~hd;
        occ <= occ + {1'b0, inf} - {1'b0, pop};
      end
    end
  end

`ifdef MLAB_RD_GRAY_EN
  logic [ADDR_WIDTH:0] rptr_q;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) rptr_q <= '0;
    else     rptr_q <= rp_nxt ^ (rp_nxt >> 1);
  end

  assign rptr = rptr_q;
`else
  assign rptr = rp;
`endif

endmodule
